// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: pointer width default,
// depth derivation and gray/binary pointer conversions used by both
// the write-side and read-side controllers.
package fifo_pkg;

    // Default pointer width including the wrap bit (depth 256).
    localparam int FIFO_ADDR_WIDTH = 9;

    // Widest pointer the conversion helpers handle. Narrower pointers are
    // zero-extended into this width and the result cast back, which keeps
    // the helpers width-agnostic (gray of a zero-extended value is the
    // zero-extended gray, and likewise for the inverse).
    localparam int PTR_MAX_W = 32;

    // Number of storage entries addressed by a pointer of the given width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << (addr_width - 1);
    endfunction

    // Binary to reflected gray code.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary via a log-depth prefix XOR from the MSB downwards.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = g;
        for (int sh = 1; sh < PTR_MAX_W; sh = sh << 1) begin
            b = b ^ (b >> sh);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchronizer carrying the read-domain gray pointer into the
// write clock domain. Gray coding guarantees at most one bit is in flight
// per read-side update, so the captured value is always either the old
// or the new pointer.
module sync_r2w
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [ADDR_WIDTH-1:0] rptr_gray,
    output logic [ADDR_WIDTH-1:0] rq2
);

    logic [ADDR_WIDTH-1:0] rq1;

    // Metastability filter: first stage samples the asynchronous pointer,
    // second stage presents a settled value to write-side logic.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rptr_gray;
            rq2 <= rq1;
        end
    end

endmodule

// File: rtl/write_control.sv
// Write-side pointer and flag controller of the dual-clock FIFO.
// Owns the binary/gray write pointer, gates memory writes against the
// full condition, and publishes registered full, almost-full, fill level
// and sticky overflow status to the producer.
module write_control
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int AFULL_THRESH = 248
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH-1:0] rptr_gray,
    output logic                  wen,
    output logic [ADDR_WIDTH-2:0] waddr,
    output logic [ADDR_WIDTH-1:0] wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH-1:0] wcount,
    output logic                  woverflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    // Out-of-range thresholds are pulled into 1..DEPTH so the flag stays
    // meaningful instead of being stuck high or never asserting.
    localparam int AFULL_CLAMP = (AFULL_THRESH < 1)     ? 1 :
                                 (AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH;
    localparam logic [ADDR_WIDTH-1:0] AFULL_LVL = ADDR_WIDTH'(AFULL_CLAMP);

    logic [ADDR_WIDTH-1:0] wbin;
    logic [ADDR_WIDTH-1:0] wbin_next;
    logic [ADDR_WIDTH-1:0] wgray_next;
    logic [ADDR_WIDTH-1:0] rq2;
    logic [ADDR_WIDTH-1:0] rbin_s;
    logic [ADDR_WIDTH-1:0] full_match;
    logic [ADDR_WIDTH-1:0] wlevel_next;
    logic                  write_ok;
    logic                  ovf_event;

    sync_r2w #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sync_r2w (
        .wclk      (wclk),
        .wrst      (wrst),
        .rptr_gray (rptr_gray),
        .rq2       (rq2)
    );

    // A write is committed only when requested, not full, and not in reset;
    // reset must never leak a memory write.
    assign write_ok  = winc && !wfull && !wrst;
    assign wen       = write_ok;
    assign ovf_event = winc && wfull;

    assign wbin_next  = wbin + ADDR_WIDTH'(write_ok);
    assign wgray_next = ADDR_WIDTH'(bin2gray(32'(wbin_next)));
    assign rbin_s     = ADDR_WIDTH'(gray2bin(32'(rq2)));

    // Full when the next write pointer equals the synchronized read pointer
    // with the two top gray bits inverted (one full lap ahead).
    assign full_match  = {~rq2[ADDR_WIDTH-1:ADDR_WIDTH-2], rq2[ADDR_WIDTH-3:0]};

    // Occupancy against a stale read pointer: can only over-report.
    assign wlevel_next = wbin_next - rbin_s;

    assign waddr = wbin[ADDR_WIDTH-2:0];

    // Pointer, level and flag registers all advance from the same next-state
    // so full/count/almost-full are mutually consistent every cycle.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= (wgray_next == full_match);
            walmost_full <= (wlevel_next >= AFULL_LVL);
            wcount       <= wlevel_next;
        end
    end

    // Sticky overflow: a dropped write sets it, and a set in the same cycle
    // as a clear request wins so no overflow is ever lost.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            woverflow <= 1'b0;
        end else if (ovf_event) begin
            woverflow <= 1'b1;
        end else if (ovf_clr) begin
            woverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_write_control.sv
module tb_write_control;

    localparam int AW = 9;

    logic          wclk = 1'b0;
    logic          wrst;
    logic          winc;
    logic          ovf_clr;
    logic [AW-1:0] rptr_gray;
    logic          wen;
    logic [AW-2:0] waddr;
    logic [AW-1:0] wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW-1:0] wcount;
    logic          woverflow;

    write_control #(
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (248)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .ovf_clr      (ovf_clr),
        .rptr_gray    (rptr_gray),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    // One expected observation: registered outputs as they stand before the
    // step's clock edge, plus wen for the step's inputs. inv=1 means only
    // structural properties are checked.
    typedef struct {
        bit            inv;
        bit            wen;
        bit            wfull;
        bit            waf;
        bit            ovf;
        logic [AW-1:0] wptr;
        logic [AW-2:0] waddr;
        logic [AW-1:0] wcount;
        string         tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [AW-1:0] to_gray(input int b);
        logic [AW-1:0] v;
        logic [AW-1:0] r;
        v = AW'(b);
        for (int i = 0; i < AW - 1; i++) r[i] = v[i] ^ v[i+1];
        r[AW-1] = v[AW-1];
        return r;
    endfunction

    function automatic logic [AW-1:0] from_gray(input logic [AW-1:0] g);
        logic [AW-1:0] r;
        r[AW-1] = g[AW-1];
        for (int i = AW - 2; i >= 0; i--) r[i] = r[i+1] ^ g[i];
        return r;
    endfunction

    function automatic exp_t mk(input string tag, input logic [AW-1:0] p, input int a,
                                input int c, input bit e, input bit f, input bit af, input bit o);
        exp_t x;
        x.inv = 1'b0; x.tag = tag; x.wptr = p; x.waddr = (AW-1)'(a); x.wcount = AW'(c);
        x.wen = e; x.wfull = f; x.waf = af; x.ovf = o;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    logic [AW-1:0] prev_wptr = '0;
    always @(negedge wclk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (!e.inv) begin
                chk({e.tag, " wen"},    32'(wen),          32'(e.wen));
                chk({e.tag, " wfull"},  32'(wfull),        32'(e.wfull));
                chk({e.tag, " afull"},  32'(walmost_full), 32'(e.waf));
                chk({e.tag, " ovf"},    32'(woverflow),    32'(e.ovf));
                chk({e.tag, " wptr"},   32'(wptr),         32'(e.wptr));
                chk({e.tag, " waddr"},  32'(waddr),        32'(e.waddr));
                chk({e.tag, " wcount"}, 32'(wcount),       32'(e.wcount));
            end else begin
                chk({e.tag, " count<=depth"}, 32'(wcount <= 9'd256), 32'd1);
                if (wfull) chk({e.tag, " full->count"}, 32'(wcount), 32'd256);
                chk({e.tag, " gray step"}, 32'($countones(wptr ^ prev_wptr) <= 1), 32'd1);
                chk({e.tag, " wen"}, 32'(wen), 32'(winc && !wfull));
            end
        end
        prev_wptr <= wptr;
    end

    task automatic step(input bit r, input bit wi, input bit clr, input int rb,
                        input bit en, input exp_t e);
        @(posedge wclk);
        #1;
        wrst = r; winc = wi; ovf_clr = clr; rptr_gray = to_gray(rb);
        if (en) q.push_back(e);
    endtask

    exp_t          none;
    logic [AW-1:0] rbin_r;
    logic [AW-1:0] dut_wbin;
    bit            wi;

    initial begin
        none = mk("none", '0, 0, 0, 0, 0, 0, 0);
        wrst = 1'b1; winc = 1'b1; ovf_clr = 1'b0; rptr_gray = '0;

        // Reset held two edges with winc=1
        step(1, 1, 0, 0, 1, mk("reset1", 9'h000, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 1, mk("reset2", 9'h000, 0, 0, 0, 0, 0, 0));

        // Fill 256 entries against a stationary read pointer
        for (int i = 0; i < 256; i++)
            step(0, 1, 0, 0, 1, mk("fill", to_gray(i), i % 256, i, 1, 0, i >= 248, 0));

        // Overflow attempts and sticky clear behaviour
        step(0, 1, 0, 0, 1, mk("ovf1",  9'h180, 0, 256, 0, 1, 1, 0));
        step(0, 1, 0, 0, 1, mk("ovf2",  9'h180, 0, 256, 0, 1, 1, 1));
        step(0, 1, 0, 0, 1, mk("ovf3",  9'h180, 0, 256, 0, 1, 1, 1));
        step(0, 0, 1, 0, 1, mk("clr",   9'h180, 0, 256, 0, 1, 1, 1));
        step(0, 0, 0, 0, 1, mk("clred", 9'h180, 0, 256, 0, 1, 1, 0));
        step(0, 1, 1, 0, 1, mk("setwin", 9'h180, 0, 256, 0, 1, 1, 0));
        step(0, 0, 1, 0, 1, mk("setwon", 9'h180, 0, 256, 0, 1, 1, 1));

        // Drain: read pointer jumps to 16; flags react on the third edge
        step(0, 0, 0, 16, 1, mk("drain0", 9'h180, 0, 256, 0, 1, 1, 0));
        step(0, 0, 0, 16, 1, mk("drain1", 9'h180, 0, 256, 0, 1, 1, 0));
        step(0, 0, 0, 16, 1, mk("drain2", 9'h180, 0, 256, 0, 1, 1, 0));
        for (int j = 0; j < 16; j++)
            step(0, 1, 0, 16, 1, mk("refill", to_gray(256 + j), j, 240 + j, 1, 0, (240 + j) >= 248, 0));

        // Read pointer catches up to 272 (empty), then write to the wrap
        step(0, 0, 0, 272, 1, mk("refull", 9'h198, 16, 256, 0, 1, 1, 0));
        step(0, 0, 0, 272, 1, mk("sync1",  9'h198, 16, 256, 0, 1, 1, 0));
        step(0, 0, 0, 272, 1, mk("sync2",  9'h198, 16, 256, 0, 1, 1, 0));
        for (int k = 0; k < 239; k++)
            step(0, 1, 0, 272, 1, mk("advance", to_gray(272 + k), (272 + k) % 256, k, 1, 0, 0, 0));
        step(0, 1, 0, 272, 1, mk("at511", 9'h100, 255, 239, 1, 0, 0, 0));
        step(0, 0, 0, 412, 1, mk("wrapped", 9'h000, 0, 240, 0, 0, 0, 0));

        // Mid-operation reset with a write request pending at level 100
        step(0, 0, 0, 412, 1, mk("pre_rst1", 9'h000, 0, 240, 0, 0, 0, 0));
        step(0, 0, 0, 412, 1, mk("pre_rst2", 9'h000, 0, 240, 0, 0, 0, 0));
        step(1, 1, 0, 412, 1, mk("rst_mid", 9'h000, 0, 100, 0, 0, 0, 0));
        step(0, 0, 0, 0,   1, mk("post_rst", 9'h000, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0,   1, mk("post_rst2", 9'h000, 0, 0, 0, 0, 0, 0));

        // Random producer/consumer traffic with structural checks
        rbin_r = '0;
        for (int n = 0; n < 600; n++) begin
            exp_t e;
            e = none;
            e.inv = 1'b1;
            e.tag = "rand";
            dut_wbin = from_gray(wptr);
            if ($urandom_range(0, 2) == 0 && rbin_r != dut_wbin) rbin_r = rbin_r + 1'b1;
            wi = ($urandom_range(0, 3) != 0);
            step(0, wi, $urandom_range(0, 7) == 0, int'(rbin_r), 1, e);
        end

        repeat (3) @(posedge wclk);
        #1;
        chk("queue drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
